// File: rtl/frequency_meter.sv
// Gated edge counter: counts rising edges of sig_in over GATE_CYCLES clocks and reports once per window.
// Optional FREQ_METER_DUTY_EN adds duty_count (clocks with synchronised sig_in high per window).
module frequency_meter #(
    parameter int unsigned GATE_CYCLES = 100000,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
`ifdef FREQ_METER_DUTY_EN
    ,
    output logic [CNT_W-1:0] duty_count
`endif
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_prev;
    logic [GATE_W-1:0]       r_gate;
    logic [CNT_W-1:0]        r_edge;
    logic                    r_sat;
    logic [CNT_W-1:0]        r_count;
    logic                    r_overflow;
    logic                    r_valid;
    logic                    r_busy;

    logic                    w_sync;
    logic                    w_rise;
    logic                    w_clear;
    logic                    w_count_en;
    logic                    w_report;
    logic                    w_edge_inc;
    logic [CNT_W-1:0]        w_edge_next;
    logic                    w_sat_next;

    // Synchroniser plus previous-value flop for rising-edge detection
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1)
                r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            else
                r_sync <= SYNC_STAGES'(sig_in);
            r_prev <= w_sync;
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and datapath strobes; dropping enable aborts without a report
    always_comb begin
        w_next     = r_state;
        w_clear    = 1'b0;
        w_count_en = 1'b0;
        w_report   = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_next = ARM;
            end
            ARM: begin
                w_clear = 1'b1;
                w_next  = enable ? MEASURE : IDLE;
            end
            MEASURE: begin
                if (!enable) begin
                    w_next = IDLE;
                end else begin
                    w_count_en = 1'b1;
                    if (r_gate == GATE_LAST) begin
                        w_next   = REPORT;
                        w_report = 1'b1;
                    end
                end
            end
            REPORT: begin
                w_next = enable ? ARM : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Saturating increment; the final gate cycle's edge is folded into the reported value
    assign w_edge_inc  = w_count_en & w_rise;
    assign w_edge_next = (w_edge_inc && (r_edge != CNT_MAX)) ? r_edge + CNT_W'(1) : r_edge;
    assign w_sat_next  = r_sat | (w_edge_inc && (r_edge == CNT_MAX));

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_gate     <= '0;
            r_edge     <= '0;
            r_sat      <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_clear) begin
                r_gate <= '0;
                r_edge <= '0;
                r_sat  <= 1'b0;
            end else if (w_count_en) begin
                if (r_gate != GATE_LAST)
                    r_gate <= r_gate + GATE_W'(1);
                r_edge <= w_edge_next;
                r_sat  <= w_sat_next;
            end
            if (w_report) begin
                r_count    <= w_edge_next;
                r_overflow <= w_sat_next;
            end
            r_valid <= w_report;
            r_busy  <= (w_next != IDLE);
        end
    end

    assign count       = r_count;
    assign overflow    = r_overflow;
    assign count_valid = r_valid;
    assign busy        = r_busy;

`ifdef FREQ_METER_DUTY_EN
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] r_duty_out;
    logic [CNT_W-1:0] w_duty_next;

    assign w_duty_next = (w_count_en && w_sync && (r_duty != CNT_MAX)) ? r_duty + CNT_W'(1) : r_duty;

    // High-time counter shares the gate window and report timing with the edge counter
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_duty     <= '0;
            r_duty_out <= '0;
        end else begin
            if (w_clear)         r_duty <= '0;
            else if (w_count_en) r_duty <= w_duty_next;
            if (w_report)        r_duty_out <= w_duty_next;
        end
    end

    assign duty_count = r_duty_out;
`endif

endmodule

// File: tb/tb_frequency_meter.sv
// Bench for frequency_meter: two instances (wide and 3-bit counters) share one stimulus.
// Expected window results are queued per instance and checked when count_valid fires.
module tb_frequency_meter;

    logic        clk_100MHz;
    logic        rst;
    logic        enable;
    logic        sig_in;
    logic [19:0] count_a;
    logic        valid_a, ovf_a, busy_a;
    logic [2:0]  count_b;
    logic        valid_b, ovf_b, busy_b;
`ifdef FREQ_METER_DUTY_EN
    logic [19:0] duty_a;
    logic [2:0]  duty_b;
`endif

    frequency_meter #(.GATE_CYCLES(100), .CNT_W(20), .SYNC_STAGES(2)) u_dut_a (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .enable     (enable),
        .sig_in     (sig_in),
        .count      (count_a),
        .count_valid(valid_a),
        .overflow   (ovf_a),
        .busy       (busy_a)
`ifdef FREQ_METER_DUTY_EN
        ,
        .duty_count (duty_a)
`endif
    );

    frequency_meter #(.GATE_CYCLES(100), .CNT_W(3), .SYNC_STAGES(2)) u_dut_b (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .enable     (enable),
        .sig_in     (sig_in),
        .count      (count_b),
        .count_valid(valid_b),
        .overflow   (ovf_b),
        .busy       (busy_b)
`ifdef FREQ_METER_DUTY_EN
        ,
        .duty_count (duty_b)
`endif
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        int period;
        int high;
        int windows;
        int cnt_a;
        int ovf_a;
        int cnt_b;
        int ovf_b;
        int duty_a;
        int duty_b;
    } vec_t;

    typedef struct {
        bit dc;
        int cnt;
        int ovf;
        int duty;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t vecs[7];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int period = 1;
    int high   = 0;
    int ph     = 0;
    bit prev_a = 1'b0;
    bit prev_b = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_wave(input int p, input int h);
        period = p;
        high   = h;
        ph     = 0;
        sig_in = (h > 0);
    endtask

    task automatic push(input bit dc, input int ca, input int oa, input int da,
                        input int cb, input int ob, input int db);
        exp_t e;
        e.dc = dc; e.cnt = ca; e.ovf = oa; e.duty = da;
        q_a.push_back(e);
        e.cnt = cb; e.ovf = ob; e.duty = db;
        q_b.push_back(e);
    endtask

    // One clock: sample outputs after the edge, score any report, advance the input wave
    task automatic tick();
        exp_t e;
        @(posedge clk_100MHz);
        #2;
        cyc++;
        if (!rst) begin
            if (valid_a) begin
                chk("valid_a_single_cycle", int'(prev_a), 0);
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL valid_a_unexpected count=%0d (no report expected, cycle %0d)", count_a, cyc);
                end else begin
                    e = q_a.pop_front();
                    if (!e.dc) begin
                        chk("count_a", int'(count_a), e.cnt);
                        chk("overflow_a", int'(ovf_a), e.ovf);
`ifdef FREQ_METER_DUTY_EN
                        chk("duty_a", int'(duty_a), e.duty);
`endif
                    end
                end
            end
            if (valid_b) begin
                chk("valid_b_single_cycle", int'(prev_b), 0);
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL valid_b_unexpected count=%0d (no report expected, cycle %0d)", count_b, cyc);
                end else begin
                    e = q_b.pop_front();
                    if (!e.dc) begin
                        chk("count_b", int'(count_b), e.cnt);
                        chk("overflow_b", int'(ovf_b), e.ovf);
`ifdef FREQ_METER_DUTY_EN
                        chk("duty_b", int'(duty_b), e.duty);
`endif
                    end
                end
            end
        end
        prev_a = valid_a;
        prev_b = valid_b;
        ph     = (ph + 1 >= period) ? 0 : ph + 1;
        sig_in = (ph < high);
    endtask

    task automatic wait_sb(input int limit);
        int n;
        n = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) begin
            checks++; errors++;
            $display("FAIL report_timeout pending_a=%0d pending_b=%0d after %0d cycles", q_a.size(), q_b.size(), n);
            q_a.delete();
            q_b.delete();
        end
    endtask

    initial begin
        int t0;
        int n;

        //          period high win cnt_a ovf_a cnt_b ovf_b duty_a duty_b
        vecs[0] = '{100,   50,  2,   1,   0,    1,    0,    50,    7};
        vecs[1] = '{10,     5,  2,  10,   0,    7,    1,    50,    7};
        vecs[2] = '{20,    10,  2,   5,   0,    5,    0,    50,    7};
        vecs[3] = '{4,      2,  2,  25,   0,    7,    1,    50,    7};
        vecs[4] = '{1,      0,  2,   0,   0,    0,    0,     0,    0};
        vecs[5] = '{10,     3,  2,  10,   0,    7,    1,    30,    7};
        vecs[6] = '{1,      1,  2,   0,   0,    0,    0,   100,    7};

        rst    = 1'b1;
        enable = 1'b0;
        set_wave(100, 50);
        #1;
        chk("reset_count_a", int'(count_a), 0);
        chk("reset_valid_a", int'(valid_a), 0);
        chk("reset_overflow_a", int'(ovf_a), 0);
        chk("reset_busy_a", int'(busy_a), 0);
        chk("reset_busy_b", int'(busy_b), 0);

        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_busy_a", int'(busy_a), 0);

        enable = 1'b1;
        repeat (2) tick();
        chk("armed_busy_a", int'(busy_a), 1);

        // Each pattern change leaves one mixed window, scored as don't-care
        for (int i = 0; i < 7; i++) begin
            set_wave(vecs[i].period, vecs[i].high);
            push(1'b1, 0, 0, 0, 0, 0, 0);
            for (int w = 0; w < vecs[i].windows; w++)
                push(1'b0, vecs[i].cnt_a, vecs[i].ovf_a, vecs[i].duty_a,
                     vecs[i].cnt_b, vecs[i].ovf_b, vecs[i].duty_b);
            wait_sb((vecs[i].windows + 2) * 102 + 50);
        end

        // Back-to-back windows report every GATE_CYCLES + 2 clocks
        set_wave(10, 5);
        push(1'b1, 0, 0, 0, 0, 0, 0);
        push(1'b0, 10, 0, 50, 7, 1, 7);
        wait_sb(400);
        t0 = cyc;
        push(1'b0, 10, 0, 50, 7, 1, 7);
        wait_sb(300);
        chk("valid_period", cyc - t0, 102);

        // Abort mid-measure: no report, held outputs, busy drops
        repeat (52) tick();
        chk("measuring_busy_a", int'(busy_a), 1);
        enable = 1'b0;
        tick();
        tick();
        chk("abort_busy_a", int'(busy_a), 0);
        chk("abort_busy_b", int'(busy_b), 0);
        repeat (200) tick();
        chk("abort_count_held_a", int'(count_a), 10);
        chk("abort_overflow_held_b", int'(ovf_b), 1);
        chk("abort_count_held_b", int'(count_b), 7);

        // Asynchronous reset mid-measure clears outputs before the next edge
        enable = 1'b1;
        push(1'b1, 0, 0, 0, 0, 0, 0);
        push(1'b0, 10, 0, 50, 7, 1, 7);
        wait_sb(400);
        repeat (30) tick();
        chk("pre_reset_count_a", int'(count_a), 10);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_count_a", int'(count_a), 0);
        chk("async_reset_overflow_b", int'(ovf_b), 0);
        chk("async_reset_valid_a", int'(valid_a), 0);
        chk("async_reset_busy_a", int'(busy_a), 0);
        repeat (3) tick();
        q_a.delete();
        q_b.delete();
        push(1'b1, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_a && n < 300);
        chk("first_report_latency", n, 102);
        push(1'b0, 10, 0, 50, 7, 1, 7);
        wait_sb(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frequency_meter.md
Name: frequency_meter

Overview:
- Measures the frequency of a slow external or derived clock, `sig_in` (e.g. the 1 MHz divided clock or a DDS output), by counting its rising edges over a fixed gate window timed by `clk_100MHz`.
- Publishes the edge count once per window with a one-cycle valid strobe.
- Sits beside the clock divider and DDS core as a self-check and measurement block.

Parameters:
- GATE_CYCLES, 100000, gate window length in `clk_100MHz` cycles (100000 = 1 ms, so count reads directly in kHz).
- CNT_W, 20, width of the edge counter and of `count`.
- SYNC_STAGES, 2, synchroniser depth for `sig_in` (minimum 2).

Ports:
- clk_100MHz  in  1  system clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = run windows back to back, 0 = stop / abort.
- sig_in  in  1  asynchronous signal under measurement.
- count  out  CNT_W  edge count of the last completed window.
- count_valid  out  1  one-cycle pulse when `count` updates.
- overflow  out  1  1 = last completed window saturated.
- busy  out  1  1 while a window is in progress (states ARM, MEASURE, REPORT).

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Reset forces all registers to 0 immediately, without waiting for a clock edge: synchroniser, edge-detect flop, gate counter, edge counter, state = IDLE.
  - Outputs during reset: `count`=0, `count_valid`=0, `overflow`=0, `busy`=0.
  - Reset mid-window discards the partial measurement.
- Input path:
  - `sig_in` passes through SYNC_STAGES flops, then one "previous" flop.
  - rise = sync & ~prev.
  - Latency from a pin edge to the counted edge is SYNC_STAGES+1 cycles.
- State machine:
  - IDLE: `busy`=0. Go to ARM when `enable`=1.
  - ARM (1 cycle): clear gate counter and edge counter. Go to MEASURE.
  - MEASURE:
    - Gate counter runs 0..GATE_CYCLES-1.
    - Each cycle with rise=1 increments the edge counter.
    - When the gate counter reaches GATE_CYCLES-1, go to REPORT. A rise in that final cycle is counted.
  - REPORT (1 cycle):
    - `count` <= edge counter; `overflow` <= saturation flag; `count_valid`=1.
    - Next state is ARM if `enable`=1, otherwise IDLE.
- Dead time: edges arriving during REPORT and ARM are not counted (2 dead cycles per window). Each window therefore spans exactly GATE_CYCLES counted cycles.
- Saturation: the edge counter stops at 2^CNT_W-1 and never wraps. A separate saturation flag is set on an increment attempted at the maximum value and is cleared in ARM.
- Abort: if `enable`=0 during ARM or MEASURE, go to IDLE next cycle. No `count_valid` is issued, and `count`/`overflow` keep their previous values.
- Held outputs: `count` and `overflow` hold between REPORT cycles. `count_valid` is never high for two consecutive cycles.
- Gate counter width is $clog2(GATE_CYCLES), with no terminal overshoot.

Optional Feature:
- Macro: FREQ_METER_DUTY_EN.
- When defined:
  - Adds output port `duty_count` (out, CNT_W).
  - Counts cycles in MEASURE where the synchronised `sig_in`=1, saturating at 2^CNT_W-1.
  - `duty_count` is cleared in ARM, latched in REPORT alongside `count`, and reset to 0.
- When undefined: the port and its logic are absent. Everything else is identical.

Test Plan:
- GATE_CYCLES=100, CNT_W=20, `enable`=1, `sig_in` = square wave of period 100 cycles -> every window reports `count`=1, `overflow`=0; `count_valid` pulses every 102 cycles.
- Same setup, `sig_in` period 10 cycles -> `count`=10 every window. Change to period 20 mid-run -> the first fully-new window reports 5.
- CNT_W=3, GATE_CYCLES=100, `sig_in` period 4 -> `count`=7, `overflow`=1. Next window with `sig_in` held at 0 -> `count`=0, `overflow`=0.
- `enable` dropped 50 cycles into MEASURE -> no `count_valid`, `count` keeps its prior value (10), `busy`=0 two cycles after `enable` falls.
- Assert `rst` asynchronously mid-MEASURE with `count`=10 -> `count`, `overflow`, `count_valid`, `busy` go to 0 before the next clock edge. After release with `enable`=1, first report arrives 102 cycles later.
- FREQ_METER_DUTY_EN defined, `sig_in` period 10 with 3 cycles high -> `count`=10, `duty_count`=30. Constant `sig_in`=1 -> `count`=0, `duty_count`=100.
